// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO.
// Frames are sent back-to-back while the FIFO holds data; the line idles high otherwise.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCW   = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (fifo_count != FCW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- transmitter FSM ----------------
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic                 stop_idx, stop_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_nxt;
  logic                 tx_nxt, done_nxt, load, tick, head_par;

  assign tick     = (baud_cnt == CNT_W'(DIV - 1));
  assign head_par = (PARITY == 1) ? ~(^head) : (^head);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? '0 : baud_cnt + 1'b1;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    done_nxt  = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    tx_nxt    = 1'b1;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
            stop_nxt  = 1'b0;
          end else begin
            bit_nxt   = bit_idx + 1'b1;
            shreg_nxt = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_nxt = ST_STOP;
          stop_nxt  = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            done_nxt = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else             state_nxt = ST_IDLE;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      shreg_nxt = head;
      par_nxt   = head_par;
      state_nxt = ST_START;
    end

    // Every symbol gets a full DIV cycles, so the counter restarts on any state entry.
    if (state_nxt != state || state == ST_IDLE) cnt_nxt = '0;

    // The line is registered, so it is driven from where the FSM is going next.
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
      ST_PARITY: tx_nxt = par_nxt;
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      uart_tx  <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_HZ=1600, BAUD=100 (16 cycles per bit).
// Four instances cover plain 8N1 with a 4-deep FIFO, even parity, odd parity and 7-bit/2-stop framing.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [4];
  logic [3:0] vld;
  logic [3:0] rdy, line, bsy, done;
  logic [2:0] cnt0;
  logic [4:0] cnt1, cnt2, cnt3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .tx_data(din[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .uart_tx(line[0]), .busy(bsy[0]), .tx_done(done[0]), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .tx_data(din[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .uart_tx(line[1]), .busy(bsy[1]), .tx_done(done[1]), .fifo_count(cnt1));

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rst(rst), .tx_data(din[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .uart_tx(line[2]), .busy(bsy[2]), .tx_done(done[2]), .fifo_count(cnt2));

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_d (
    .clk(clk), .rst(rst), .tx_data(din[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .uart_tx(line[3]), .busy(bsy[3]), .tx_done(done[3]), .fifo_count(cnt3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte on instance k and return #1 after the edge that accepted it.
  task automatic push(input int k, input logic [7:0] b);
    int n = 0;
    din[k] = b;
    vld[k] = 1'b1;
    while (!rdy[k] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", 32'(rdy[k]), 32'd1);
    @(posedge clk); #1;
    vld[k] = 1'b0;
  endtask

  // Called #1 after the edge that entered START; checks n symbols of 16 cycles each.
  task automatic expect_frame(input int k, input logic [15:0] syms, input int n, input string tag);
    int          good = 0;
    logic [15:0] mid  = '0;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < 16; c++) begin
        if (line[k] === syms[s]) good++;
        if (c == 8) mid[s] = line[k];
        @(posedge clk); #1;
      end
    end
    check({tag, "_bits"}, 32'(mid), 32'(syms));
    check({tag, "_cycles"}, good, n * 16);
  endtask

  task automatic frame8(input logic [7:0] b, input string tag);
    expect_frame(0, {6'b0, 1'b1, b, 1'b0}, 10, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    logic [7:0] fifo_bytes [6];
    logic [7:0] ord_bytes [4];
    fifo_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ord_bytes  = '{8'h3C, 8'hC3, 8'h81, 8'h7E};

    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    // Reset values appear before any clock edge.
    #1;
    check("rst_line",  32'(line),  32'hF);
    check("rst_busy",  32'(bsy),   32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_ready", 32'(rdy),   32'hF);
    check("rst_count", 32'(cnt0),  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle_line", 32'(line), 32'hF);

    // 8N1 frame of 0xA5: accepted at edge N, start bit from edge N+1.
    push(0, 8'hA5);
    check("a5_line_n",  32'(line[0]), 32'd1);
    check("a5_count_n", 32'(cnt0),    32'd1);
    check("a5_busy_n",  32'(bsy[0]),  32'd0);
    @(posedge clk); #1;
    check("a5_count_n1", 32'(cnt0),   32'd0);
    check("a5_busy_n1",  32'(bsy[0]), 32'd1);
    frame8(8'hA5, "a5");
    check("a5_done",      32'(done[0]), 32'd1);
    check("a5_idle_busy", 32'(bsy[0]),  32'd0);
    @(posedge clk); #1;
    check("a5_done_pulse", 32'(done[0]), 32'd0);
    check("a5_idle_line",  32'(line[0]), 32'd1);

    // Even parity of 0x07 is 1; odd parity is 0; 11 symbols each.
    push(1, 8'h07);
    @(posedge clk); #1;
    expect_frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "even07");
    check("even07_done", 32'(done[1]), 32'd1);
    push(2, 8'h07);
    @(posedge clk); #1;
    expect_frame(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "odd07");
    check("odd07_done", 32'(done[2]), 32'd1);

    // 7 data bits, 2 stop bits: bit 7 of 0xFF never reaches the line.
    push(3, 8'hFF);
    @(posedge clk); #1;
    expect_frame(3, {6'b0, 2'b11, 7'h7F, 1'b0}, 10, "d7s2");
    check("d7s2_done", 32'(done[3]), 32'd1);

    // Six bytes into a 4-deep FIFO with tx_valid held.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(0, fifo_bytes[i]);
          vld[0] = 1'b1;
          if (i == 4) begin
            check("full_count", 32'(cnt0),    32'd4);
            check("full_ready", 32'(rdy[0]),  32'd0);
          end
        end
        vld[0] = 1'b0;
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) frame8(fifo_bytes[i], $sformatf("fifo%0d", i));
      end
    join
    check("fifo_end_count", 32'(cnt0),    32'd0);
    check("fifo_end_busy",  32'(bsy[0]),  32'd0);
    check("fifo_end_line",  32'(line[0]), 32'd1);

    // Reset in the middle of data bit 3 with two bytes queued.
    push(0, 8'h00);
    push(0, 8'h12);
    push(0, 8'h34);
    check("pre_rst_count", 32'(cnt0), 32'd2);
    repeat (71) @(posedge clk);
    #1;
    check("pre_rst_line", 32'(line[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_line",  32'(line[0]), 32'd1);
    check("mid_rst_count", 32'(cnt0),    32'd0);
    check("mid_rst_busy",  32'(bsy[0]),  32'd0);
    check("mid_rst_ready", 32'(rdy[0]),  32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (line[0] === 1'b1 && bsy[0] === 1'b0) ok++;
    end
    check("post_rst_quiet", ok, 100);
    check("post_rst_count", 32'(cnt0), 32'd0);
    push(0, 8'h5A);
    @(posedge clk); #1;
    frame8(8'h5A, "post_rst");

    // Push coinciding with the pop at the final stop edge while two are queued.
    fork
      begin
        push(0, ord_bytes[0]);
        push(0, ord_bytes[1]);
        push(0, ord_bytes[2]);
        check("simul_pre_count", 32'(cnt0), 32'd2);
        repeat (158) @(posedge clk);
        #1;
        check("simul_hold_count", 32'(cnt0), 32'd2);
        push(0, ord_bytes[3]);
        check("simul_count", 32'(cnt0),    32'd2);
        check("simul_start", 32'(line[0]), 32'd0);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) frame8(ord_bytes[i], $sformatf("order%0d", i));
      end
    join
    check("order_end_count", 32'(cnt0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8: payload bits per frame.
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port tx_data, input, 8: byte to send; bits above DATA_BITS-1 ignored.
REQ-010 SHALL have port tx_valid, input, 1: tx_data is presented.
REQ-011 SHALL have port tx_ready, output, 1: FIFO can accept; equals not-full.
REQ-012 SHALL have port uart_tx, output, 1: serial line, registered, idle high.
REQ-013 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-014 SHALL have port tx_done, output, 1: one-cycle pulse at the end of each frame.
REQ-015 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1: entries held.

Function
REQ-016 SHALL set the bit period DIV to (CLK_HZ + BAUD/2) / BAUD clock cycles, which is 217 for the defaults.
REQ-017 SHALL restart the baud counter at 0 on every state entry and advance state when the counter reaches DIV-1, so each line symbol lasts exactly DIV cycles.
REQ-018 SHALL accept a write on an edge where tx_valid and tx_ready are both high; tx_ready SHALL be 0 while fifo_count equals FIFO_DEPTH.
REQ-019 SHALL leave fifo_count unchanged on simultaneous push and pop; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-021 SHALL, in IDLE with the FIFO non-empty, pop the head entry into the shift register on the next edge and enter START with uart_tx driven to 0.
REQ-022 SHALL leave IDLE for START, on a write into an empty FIFO accepted at edge N, at edge N+1.
REQ-023 SHALL go from START to DATA, and then shift DATA_BITS bits LSB first.
REQ-024 SHALL leave DATA for PARITY if PARITY is non-zero, else for STOP.
REQ-025 SHALL drive the PARITY bit as the XOR of the payload bits for even parity, inverted for odd parity.
REQ-026 SHALL drive uart_tx to 1 in STOP for STOP_BITS times DIV cycles.
REQ-027 SHALL pulse tx_done high for one cycle on the final STOP edge.
REQ-028 SHALL, at the final STOP edge with the FIFO non-empty, pop and enter START on that same edge, leaving no idle cycle between frames.
REQ-029 SHALL, at the final STOP edge with the FIFO empty, enter IDLE with uart_tx held at 1.
REQ-030 SHALL never corrupt a frame in progress through FIFO activity, including a full FIFO with a push refused during transmission.
REQ-031 SHALL use only the data bits defined by DATA_BITS, with no truncation warnings; tx_data[7:DATA_BITS] SHALL never appear on the line.

Reset
REQ-032 SHALL, on rst high, immediately and asynchronously force uart_tx=1, busy=0, tx_done=0, tx_ready=1, fifo_count=0, FSM=IDLE, baud counter=0 and FIFO pointers=0.
REQ-033 SHALL, on reset asserted mid-frame, abort the frame, discard the FIFO contents and return the line to idle high with no further bits sent.
REQ-034 SHALL start the first frame at the first write accepted after rst deasserts.

Verification (bench parameters CLK_HZ=1600, BAUD=100, giving DIV=16)
REQ-035 SHALL cover: DATA_BITS=8, PARITY=0, STOP_BITS=1, write 0xA5 -> uart_tx low from edge N+1 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; tx_done pulses at cycle N+1+160.
REQ-036 SHALL cover: PARITY=2, write 0x07 -> parity bit 1; PARITY=1, write 0x07 -> parity bit 0; frame length 11x16 cycles.
REQ-037 SHALL cover: DATA_BITS=7, STOP_BITS=2, write 0xFF -> seven 1 data bits, stop high for 32 cycles, frame 10x16 cycles.
REQ-038 SHALL cover: FIFO_DEPTH=4, write 6 bytes back-to-back with tx_valid held -> tx_ready low once count reaches 4, all 6 bytes sent in order, no idle gap between frames, fifo_count ends at 0.
REQ-039 SHALL cover: rst pulsed during data bit 3 with 2 bytes queued -> uart_tx=1 in the same cycle, fifo_count=0, no further falling edge until a new write.
REQ-040 SHALL cover: simultaneous push and pop while count=2 -> count stays 2 and byte order is preserved.
